// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared constants and PWL sigmoid coefficient table
package activation_pkg;

  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH    = 1'b1;

  localparam int PWL_DATA_W   = 18;
  localparam int PWL_FRAC     = 14;
  localparam int PWL_SEG_BITS = 4;
  localparam int PWL_COEF_W   = 18;
  localparam int ONE          = 1 << PWL_FRAC;

  typedef struct packed {
    logic signed [PWL_COEF_W-1:0] slope;
    logic signed [PWL_COEF_W-1:0] icpt;
  } pwl_coef_t;

  // Chords through sigmoid at x = 0.5*k, both terms in Q3.14
  function automatic pwl_coef_t coef_lookup(input logic [PWL_SEG_BITS-1:0] seg);
    pwl_coef_t c;
    case (seg)
      4'd0:    c = '{slope: 18'sd4012, icpt: 18'sd8192};
      4'd1:    c = '{slope: 18'sd3558, icpt: 18'sd8419};
      4'd2:    c = '{slope: 18'sd2836, icpt: 18'sd9141};
      4'd3:    c = '{slope: 18'sd2072, icpt: 18'sd10287};
      4'd4:    c = '{slope: 18'sd1420, icpt: 18'sd11591};
      4'd5:    c = '{slope: 18'sd932,  icpt: 18'sd12811};
      4'd6:    c = '{slope: 18'sd594,  icpt: 18'sd13825};
      4'd7:    c = '{slope: 18'sd370,  icpt: 18'sd14609};
      4'd8:    c = '{slope: 18'sd230,  icpt: 18'sd15169};
      4'd9:    c = '{slope: 18'sd140,  icpt: 18'sd15574};
      4'd10:   c = '{slope: 18'sd86,   icpt: 18'sd15844};
      4'd11:   c = '{slope: 18'sd52,   icpt: 18'sd16031};
      4'd12:   c = '{slope: 18'sd32,   icpt: 18'sd16151};
      4'd13:   c = '{slope: 18'sd20,   icpt: 18'sd16229};
      4'd14:   c = '{slope: 18'sd12,   icpt: 18'sd16285};
      default: c = '{slope: 18'sd8,    icpt: 18'sd16315};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/activation_pwl_pipe_if.sv
// rtl/activation_pwl_pipe_if.sv - sample in / result out stream pair
interface activation_pwl_pipe_if
  import activation_pkg::*;
#(
  parameter int BITWIDTH = PWL_DATA_W
);
  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic [BITWIDTH-1:0] operand;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] result;

  modport master (
    output in_valid, in_mode, operand, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, in_mode, operand, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/pwl_coef_rom.sv
// rtl/pwl_coef_rom.sv - registered segment coefficient lookup
module pwl_coef_rom
  import activation_pkg::*;
#(
  parameter int SEG_BITS = PWL_SEG_BITS,
  parameter int COEF_W   = PWL_COEF_W
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic [SEG_BITS-1:0]      seg,
  output logic signed [COEF_W-1:0] slope,
  output logic signed [COEF_W-1:0] icpt
);

  pwl_coef_t coef;

  always_comb begin
    coef = coef_lookup(seg);
  end

  always_ff @(posedge clock) begin
    if (en) begin
      slope <= coef.slope;
      icpt  <= coef.icpt;
    end
  end

endmodule

// File: rtl/activation_pwl_pipe.sv
// rtl/activation_pwl_pipe.sv - 4-stage sigmoid/tanh PWL activation with stream backpressure
module activation_pwl_pipe
  import activation_pkg::*;
#(
  parameter int BITWIDTH  = PWL_DATA_W,
  parameter int FRAC      = PWL_FRAC,
  parameter int SEG_BITS  = PWL_SEG_BITS,
  parameter int XMAX_LOG2 = 3,
  parameter int COEF_W    = PWL_COEF_W
) (
  input  logic                 clock,
  input  logic                 reset,
  activation_pwl_pipe_if.slave bus
);

  localparam int PW = COEF_W + BITWIDTH + 1;
  localparam logic [BITWIDTH-1:0]   S_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0]   S_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]  HALF  = PW'(1) << (FRAC-1);
  localparam logic signed [PW-1:0]  ONE_Y = PW'(1) << FRAC;

  logic adv;
  logic v1, v2, v3, out_valid_r;
  logic [BITWIDTH-1:0] result_r;

  logic sign1, mode1, sign2, mode2, sign3, mode3;
  logic [BITWIDTH-1:0] a1, a2;
  logic signed [COEF_W-1:0] slope_r, icpt_r, icpt3;
  logic signed [PW-1:0] p3;

  logic sign_c;
  logic [BITWIDTH-1:0] x_s, a_c;
  logic signed [PW-1:0] p_rnd, y_base, y_sym, y_mode, y_lo, y_clamp;

  // Every stage moves together; a full output register that is not taken freezes the pipe
  assign adv           = bus.out_ready || !out_valid_r;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

  always_comb begin
    sign_c = bus.operand[BITWIDTH-1];
    x_s    = bus.operand;
    if (bus.in_mode == ACT_TANH) begin
      if (bus.operand[BITWIDTH-1] != bus.operand[BITWIDTH-2])
        x_s = sign_c ? S_MIN : S_MAX;
      else
        x_s = {bus.operand[BITWIDTH-2:0], 1'b0};
    end
    if (x_s == S_MIN)
      a_c = S_MAX;
    else if (x_s[BITWIDTH-1])
      a_c = -x_s;
    else
      a_c = x_s;
  end

  pwl_coef_rom #(
    .SEG_BITS (SEG_BITS),
    .COEF_W   (COEF_W)
  ) u_rom (
    .clock (clock),
    .en    (adv),
    .seg   (a1[FRAC+XMAX_LOG2-1 -: SEG_BITS]),
    .slope (slope_r),
    .icpt  (icpt_r)
  );

  // Evaluate on |x|, then fold back through symmetry and the tanh identity
  always_comb begin
    p_rnd  = (p3 + HALF) >>> FRAC;
    y_base = PW'(icpt3) + p_rnd;
    y_sym  = sign3 ? (ONE_Y - y_base) : y_base;
    y_mode = (mode3 == ACT_TANH) ? ((y_sym <<< 1) - ONE_Y) : y_sym;
    y_lo   = (mode3 == ACT_TANH) ? -ONE_Y : '0;
    if (y_mode > ONE_Y)
      y_clamp = ONE_Y;
    else if (y_mode < y_lo)
      y_clamp = y_lo;
    else
      y_clamp = y_mode;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
    end else if (adv) begin
      v1          <= bus.in_valid;
      v2          <= v1;
      v3          <= v2;
      out_valid_r <= v3;
      if (v3)
        result_r <= BITWIDTH'(y_clamp);
    end
  end

  always_ff @(posedge clock) begin
    if (adv) begin
      sign1 <= sign_c;
      mode1 <= bus.in_mode;
      a1    <= a_c;
      sign2 <= sign1;
      mode2 <= mode1;
      a2    <= a1;
      sign3 <= sign2;
      mode3 <= mode2;
      icpt3 <= icpt_r;
      p3    <= PW'(slope_r) * PW'($signed({1'b0, a2}));
    end
  end

endmodule
